// File: rtl/rc4_prga_decrypt.sv
// RC4 pseudo-random generation stage: walks the permuted S memory, XORs each
// keystream byte with the encrypted-message ROM and writes the plaintext RAM.
// Each byte takes nine single-cycle states. All memory-facing outputs are
// decoded from registered state and datapath only.
module rc4_prga_decrypt #(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned MSG_AW  = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              finish,
    output logic              busy,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [MSG_AW-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] ram_address,
    output logic [7:0]        ram_data,
    output logic              ram_wren
);

    localparam logic [MSG_AW-1:0] KLast = MSG_AW'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        StIdle,
        StReadI,
        StWaitI,
        StReadJ,
        StWaitJ,
        StWriteI,
        StWriteJ,
        StReadF,
        StWaitF,
        StWriteOut,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic [7:0]        si_q, si_d;
    logic [7:0]        sj_q, sj_d;
    logic [7:0]        f_q, f_d;
    logic [7:0]        enc_q, enc_d;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
            enc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            enc_q   <= enc_d;
        end
    end

    // Next-state, datapath updates and memory-side outputs per state.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        si_d        = si_q;
        sj_d        = sj_q;
        f_d         = f_q;
        enc_d       = enc_q;
        finish      = 1'b0;
        s_address   = '0;
        s_data      = '0;
        s_wren      = 1'b0;
        rom_address = '0;
        ram_address = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = StReadI;
                end
            end
            StReadI: begin
                s_address = i_q + 8'd1;
                i_d       = i_q + 8'd1;
                state_d   = StWaitI;
            end
            StWaitI: begin
                si_d    = s_q;
                j_d     = j_q + s_q;
                state_d = StReadJ;
            end
            StReadJ: begin
                s_address = j_q;
                state_d   = StWaitJ;
            end
            StWaitJ: begin
                sj_d    = s_q;
                state_d = StWriteI;
            end
            StWriteI: begin
                s_address = i_q;
                s_data    = sj_q;
                s_wren    = 1'b1;
                state_d   = StWriteJ;
            end
            // When i == j this second write lands last, leaving si in place.
            StWriteJ: begin
                s_address = j_q;
                s_data    = si_q;
                s_wren    = 1'b1;
                state_d   = StReadF;
            end
            StReadF: begin
                s_address   = si_q + sj_q;
                rom_address = k_q;
                state_d     = StWaitF;
            end
            StWaitF: begin
                f_d     = s_q;
                enc_d   = rom_q;
                state_d = StWriteOut;
            end
            StWriteOut: begin
                ram_address = k_q;
                ram_data    = f_q ^ enc_q;
                ram_wren    = 1'b1;
                if (k_q == KLast) begin
                    state_d = StDone;
                end else begin
                    k_d     = k_q + MSG_AW'(1);
                    state_d = StReadI;
                end
            end
            StDone: begin
                finish  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Busy spans every non-idle state, including the finish cycle.
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt with synchronous-read memory models and a
// software RC4 keystream model computed from the S contents loaded before each run.
module tb_rc4_prga_decrypt;

    localparam int MsgLen = 32;
    localparam int MsgAw  = 5;
    localparam int Lat    = 9 * MsgLen + 1;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             finish, busy, s_wren, ram_wren;
    logic [7:0]       s_address, s_data, s_q, rom_q, ram_data;
    logic [MsgAw-1:0] rom_address, ram_address;

    logic [7:0] s_init [256];
    logic [7:0] smem   [256];
    logic [7:0] rom_mem[MsgLen];
    logic [7:0] ram_mem[MsgLen];
    logic [7:0] exp_ram[MsgLen];
    logic       load_s = 1'b0;

    int vec_n  = 0;
    int miss_n = 0;

    // Captured during a run for the hand-written corner checks.
    int         sw_n;
    logic [7:0] sw_a[2];
    logic [7:0] sw_d[2];
    logic [7:0] s2_cap, s3_cap;
    int         wr_n, ovl_n;

    typedef struct {
        int         addr;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[5];

    rc4_prga_decrypt #(
        .MSG_LEN(MsgLen),
        .MSG_AW (MsgAw)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .finish     (finish),
        .busy       (busy),
        .s_address  (s_address),
        .s_data     (s_data),
        .s_wren     (s_wren),
        .s_q        (s_q),
        .rom_address(rom_address),
        .rom_q      (rom_q),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren)
    );

    always #5 clock = ~clock;

    // Synchronous-read memories; S can be bulk-loaded from s_init.
    always @(posedge clock) begin
        s_q   <= smem[s_address];
        rom_q <= rom_mem[rom_address];
        if (load_s) begin
            for (int a = 0; a < 256; a++) smem[a] <= s_init[a];
        end else if (s_wren) begin
            smem[s_address] <= s_data;
        end
        if (ram_wren) ram_mem[ram_address] <= ram_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_n++;
        if (act !== exp) begin
            miss_n++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_s_mem();
        @(negedge clock);
        load_s = 1'b1;
        @(negedge clock);
        load_s = 1'b0;
    endtask

    task automatic set_identity();
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    endtask

    task automatic set_ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
        logic [7:0] key[3];
        logic [7:0] j, t;
        key[0] = k0; key[1] = k1; key[2] = k2;
        set_identity();
        j = 8'd0;
        for (int a = 0; a < 256; a++) begin
            j = j + s_init[a] + key[a % 3];
            t = s_init[a]; s_init[a] = s_init[j]; s_init[j] = t;
        end
    endtask

    // Reference RC4 PRGA over a copy of s_init.
    task automatic compute_exp();
        logic [7:0] ms[256];
        logic [7:0] i, j, t;
        for (int a = 0; a < 256; a++) ms[a] = s_init[a];
        i = 8'd0; j = 8'd0;
        for (int n = 0; n < MsgLen; n++) begin
            i = i + 8'd1;
            j = j + ms[i];
            t = ms[i]; ms[i] = ms[j]; ms[j] = t;
            t = ms[i] + ms[j];
            exp_ram[n] = rom_mem[n] ^ ms[t];
        end
    endtask

    // Cycle 1 is the first cycle after the edge that samples start.
    task automatic run(input int repulse_at, input int reset_at);
        int lat;
        load_s_mem();
        compute_exp();
        sw_n = 0; wr_n = 0; ovl_n = 0; lat = -1;
        @(negedge clock);
        start = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clock);
            if (cyc == 1 || cyc == repulse_at + 1) start = 1'b0;
            if (cyc == repulse_at) start = 1'b1;
            if (cyc == 1) check("busy_after_start", 32'(busy), 32'd1);
            if (s_wren && ram_wren) ovl_n++;
            if (s_wren && sw_n < 2) begin
                sw_a[sw_n] = s_address; sw_d[sw_n] = s_data; sw_n++;
            end
            if (ram_wren) begin
                wr_n++;
                if (wr_n == 2) begin s2_cap = smem[2]; s3_cap = smem[3]; end
            end
            if (cyc == reset_at) begin
                #2 reset_n = 1'b0;
                #1;
                check("rst_ctrl", {28'd0, finish, busy, s_wren, ram_wren}, 32'd0);
                check("rst_s_bus", {16'd0, s_address, s_data}, 32'd0);
                check("rst_ram_bus", {19'd0, ram_address, ram_data}, 32'd0);
                check("rst_rom_addr", 32'(rom_address), 32'd0);
                @(negedge clock);
                check("rst_still_idle", 32'(busy), 32'd0);
                reset_n = 1'b1;
                return;
            end
            if (finish) begin lat = cyc; break; end
        end
        check("finish_latency", 32'(lat), 32'(Lat));
        check("ram_wren_count", 32'(wr_n), 32'(MsgLen));
        check("wren_overlap", 32'(ovl_n), 32'd0);
        @(negedge clock);
        check("finish_pulse_end", {30'd0, finish, busy}, 32'd0);
        for (int n = 0; n < MsgLen; n++) check($sformatf("ram[%0d]", n), 32'(ram_mem[n]),
                                               32'(exp_ram[n]));
    endtask

    initial begin
        int c;
        tbl[0] = '{addr: 0, exp: 8'hAD};
        tbl[1] = '{addr: 1, exp: 8'h05};
        tbl[2] = '{addr: 2, exp: 8'h07};
        tbl[3] = '{addr: 3, exp: 8'h0D};
        tbl[4] = '{addr: 4, exp: 8'h0D};

        // Reset state.
        #1;
        check("reset_ctrl", {28'd0, finish, busy, s_wren, ram_wren}, 32'd0);
        check("reset_s_bus", {16'd0, s_address, s_data}, 32'd0);
        check("reset_ram_bus", {19'd0, ram_address, ram_data}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Identity S, ROM zero apart from rom[0].
        set_identity();
        for (int n = 0; n < MsgLen; n++) rom_mem[n] = 8'h00;
        rom_mem[0] = 8'hAF;
        run(-1, -1);
        for (int v = 0; v < 5; v++)
            check($sformatf("tbl_ram[%0d]", tbl[v].addr), 32'(ram_mem[tbl[v].addr]),
                  32'(tbl[v].exp));
        check("byte0_write_i", {16'd0, sw_a[0], sw_d[0]}, 32'h0101);
        check("byte0_write_j", {16'd0, sw_a[1], sw_d[1]}, 32'h0101);
        check("byte1_s2", 32'(s2_cap), 32'h03);
        check("byte1_s3", 32'(s3_cap), 32'h02);

        // Key-scheduled S for key 00 02 49 with a fixed ciphertext.
        set_ksa(8'h00, 8'h02, 8'h49);
        for (int n = 0; n < MsgLen; n++) rom_mem[n] = 8'(n * 37 + 11);
        run(-1, -1);

        // Same S, new ciphertext, start re-pulsed mid-run.
        for (int n = 0; n < MsgLen; n++) rom_mem[n] = 8'(n * 91 + 200);
        run(50, -1);

        // Asynchronous reset mid-message, then a fresh run.
        set_identity();
        for (int n = 0; n < MsgLen; n++) rom_mem[n] = 8'(n ^ 8'h5A);
        run(-1, 100);
        set_ksa(8'h00, 8'h02, 8'h49);
        for (int n = 0; n < MsgLen; n++) rom_mem[n] = 8'(n * 13 + 1);
        run(-1, -1);

        // Start held high: ignored in DONE, next run begins from IDLE.
        @(negedge clock);
        start = 1'b1;
        c = -1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clock);
            if (finish) begin c = cyc; break; end
        end
        check("held_latency", 32'(c), 32'(Lat));
        @(negedge clock);
        check("held_idle_gap", 32'(busy), 32'd0);
        @(negedge clock);
        check("held_restart", 32'(busy), 32'd1);
        start = 1'b0;
        c = -1;
        for (int cyc = 2; cyc <= 400; cyc++) begin
            @(negedge clock);
            if (finish) begin c = cyc; break; end
        end
        check("held_second_latency", 32'(c), 32'(Lat));

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule
